// File: rtl/rank_filter_if.sv
// Streaming sample/result bundle for the rank-order filter.
// master drives samples and rank; slave returns ready, result and strobes.
interface rank_filter_if #(
  parameter int W  = 8,
  parameter int P  = 9,
  parameter int RW = $clog2(P)
);
  logic [W-1:0]  DI;
  logic          DSI;
  logic [RW-1:0] RANK_I;
  logic          RDY;
  logic [W-1:0]  DO;
  logic          DSO;
  logic          ERR;

  modport master (output DI, DSI, RANK_I, input RDY, DO, DSO, ERR);
  modport slave  (input DI, DSI, RANK_I, output RDY, DO, DSO, ERR);
endinterface

// File: rtl/rank_filter.sv
// Streaming rank-order filter: loads a burst of P samples, runs partial bubble
// passes until the requested rank has settled, then emits that element.
module rank_filter #(
  parameter int W  = 8,
  parameter int P  = 9,
  parameter int RW = $clog2(P)
) (
  input  logic         CLK,
  input  logic         RST,
  rank_filter_if.slave bus
);
  localparam int              CW   = $clog2(P + 1);
  localparam int              IW   = $clog2(P);
  localparam logic [CW-1:0]   LAST = CW'(P - 1);
  localparam logic [CW-1:0]   MMAX = CW'(P - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SORT = 2'd2} state_t;

  function automatic logic [RW-1:0] clamp_rank(input logic [RW-1:0] rk);
    logic [RW-1:0] res;
    if (32'(rk) >= 32'(P)) begin
      res = RW'(P - 1);
    end else begin
      res = rk;
    end
    return res;
  endfunction

  state_t        state_r, state_s;
  logic [W-1:0]  arr_r [P];
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CW-1:0] m_r, m_s;
  logic [CW-1:0] idx_r, idx_s;
  logic [RW-1:0] r_r, r_s;
  logic [W-1:0]  do_r, do_s;
  logic          dso_r, dso_s;
  logic          err_r, err_s;
  logic          rdy_r, rdy_s;

  logic          wr_en_s, swp_en_s;
  logic [CW-1:0] wr_addr_s;
  logic [CW-1:0] pend_s, idx1_s, mlim_s;
  logic [W-1:0]  a_lo_s, a_hi_s, res_s;

  // pend_s is one past the last compare index of the current pass; reaching it
  // means the final pass has finished and the result can be read out.
  assign pend_s    = LAST - m_r;
  assign idx1_s    = (idx_r < LAST) ? (idx_r + CW'(1)) : idx_r;
  assign mlim_s    = (CW'(r_r) > MMAX) ? MMAX : CW'(r_r);
  assign wr_addr_s = (state_r == LOAD) ? cnt_r : {CW{1'b0}};
  assign a_lo_s    = arr_r[IW'(idx_r)];
  assign a_hi_s    = arr_r[IW'(idx1_s)];
  assign res_s     = arr_r[IW'(LAST - CW'(r_r))];

  assign bus.RDY = rdy_r;
  assign bus.DO  = do_r;
  assign bus.DSO = dso_r;
  assign bus.ERR = err_r;

  // Next-state, counter and output decode
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    m_s      = m_r;
    idx_s    = idx_r;
    r_s      = r_r;
    do_s     = do_r;
    dso_s    = 1'b0;
    err_s    = 1'b0;
    rdy_s    = rdy_r;
    wr_en_s  = 1'b0;
    swp_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        rdy_s = 1'b1;
        if (bus.DSI) begin
          wr_en_s = 1'b1;
          cnt_s   = CW'(1);
          r_s     = clamp_rank(bus.RANK_I);
          state_s = LOAD;
          rdy_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.DSI) begin
          wr_en_s = 1'b1;
          cnt_s   = cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            state_s = SORT;
            m_s     = {CW{1'b0}};
            idx_s   = {CW{1'b0}};
          end else begin
            state_s = LOAD;
          end
        end else begin
          // short burst: drop the partial window
          err_s   = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = IDLE;
          rdy_s   = 1'b1;
        end
      end
      SORT: begin
        err_s = bus.DSI;
        if (idx_r != pend_s) begin
          swp_en_s = (a_lo_s > a_hi_s);
          if (idx_r == (pend_s - CW'(1))) begin
            if (m_r == mlim_s) begin
              idx_s = idx_r + CW'(1);
            end else begin
              m_s   = m_r + CW'(1);
              idx_s = {CW{1'b0}};
            end
          end else begin
            idx_s = idx_r + CW'(1);
          end
        end else begin
          do_s    = res_s;
          dso_s   = 1'b1;
          state_s = IDLE;
          rdy_s   = 1'b1;
          cnt_s   = {CW{1'b0}};
          m_s     = {CW{1'b0}};
          idx_s   = {CW{1'b0}};
        end
      end
      default: begin
        state_s = IDLE;
        rdy_s   = 1'b1;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, latched rank and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
      m_r   <= {CW{1'b0}};
      idx_r <= {CW{1'b0}};
      r_r   <= {RW{1'b0}};
      do_r  <= {W{1'b0}};
      dso_r <= 1'b0;
      err_r <= 1'b0;
      rdy_r <= 1'b1;
    end else begin
      cnt_r <= cnt_s;
      m_r   <= m_s;
      idx_r <= idx_s;
      r_r   <= r_s;
      do_r  <= do_s;
      dso_r <= dso_s;
      err_r <= err_s;
      rdy_r <= rdy_s;
    end
  end

  // Sample array: burst writes and compare-swap moves; contents need no reset
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      arr_r[IW'(wr_addr_s)] <= bus.DI;
    end else if (swp_en_s) begin
      arr_r[IW'(idx_r)]  <= a_hi_s;
      arr_r[IW'(idx1_s)] <= a_lo_s;
    end
  end
endmodule
